// File: rtl/proto_stream_scheduler_if.sv
// Source-side bus of the stream scheduler: per-source request, length, byte stream and handshake.
// The master modport is the ingress sources; the slave modport is the scheduler.
interface proto_stream_scheduler_if #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned LEN_W = 16
);
  logic [N_SRC-1:0]       src_req_i;
  logic [N_SRC*LEN_W-1:0] src_len_i;
  logic [N_SRC*8-1:0]     src_data_i;
  logic [N_SRC-1:0]       src_valid_i;
  logic [N_SRC-1:0]       src_ready_o;
  logic [N_SRC-1:0]       src_grant_o;

  modport master (
    output src_req_i,
    output src_len_i,
    output src_data_i,
    output src_valid_i,
    input  src_ready_o,
    input  src_grant_o
  );

  modport slave (
    input  src_req_i,
    input  src_len_i,
    input  src_data_i,
    input  src_valid_i,
    output src_ready_o,
    output src_grant_o
  );
endinterface

// File: rtl/proto_stream_scheduler.sv
// Round-robin scheduler sharing one protoDeserialize among N_SRC length-framed byte sources.
// Grants whole messages, pulses the deserializer reset and hands out ring-slot base addresses.
module proto_stream_scheduler #(
  parameter int unsigned N_SRC        = 4,
  parameter int unsigned NUM_SLOTS    = 8,
  parameter int unsigned SLOT_BYTES   = 4096,
  parameter int unsigned LEN_W        = 16,
  parameter int unsigned DRAIN_CYCLES = 2,
  localparam int unsigned SRC_W       = $clog2(N_SRC),
  localparam int unsigned SLOT_W      = $clog2(NUM_SLOTS),
  localparam int unsigned USED_W      = SLOT_W + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  proto_stream_scheduler_if.slave src_if,
  input  logic [31:0]             cfg_region_base_i,
  input  logic                    slot_free_i,
  output logic [7:0]              deser_data_o,
  output logic                    deser_valid_o,
  output logic                    deser_rst_o,
  output logic [31:0]             deser_base_addr_o,
  output logic                    msg_done_o,
  output logic [SRC_W-1:0]        msg_done_src_o,
  output logic [SLOT_W-1:0]       msg_done_slot_o,
  output logic [USED_W-1:0]       slots_used_o,
  output logic                    err_zero_len_o
);
  localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_ARB,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [SRC_W-1:0]  r_rr_ptr;
  logic [SRC_W-1:0]  r_src;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [SLOT_W-1:0] r_wr_slot;
  logic [USED_W-1:0] r_used;
  logic [DRN_W-1:0]  r_drain;
  logic [31:0]       r_base;

  logic [LEN_W-1:0]  w_len_arr  [N_SRC];
  logic [7:0]        w_data_arr [N_SRC];
  logic [SRC_W-1:0]  w_winner;
  logic [SRC_W-1:0]  w_rr_next;
  logic [SRC_W-1:0]  w_idx;
  int unsigned       w_sum;
  logic              w_found;
  logic              w_not_full;
  logic              w_fire;
  logic              w_zero;
  logic              w_byte;
  logic              w_last;
  logic              w_drain_end;
  logic              w_free_ok;
  logic [N_SRC-1:0]  w_grant;
  logic [N_SRC-1:0]  w_ready;

  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      w_len_arr[i]  = src_if.src_len_i[i*LEN_W +: LEN_W];
      w_data_arr[i] = src_if.src_data_i[i*8 +: 8];
    end
  end

  // Scan starts at rr_ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    w_sum    = 0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      w_sum = 32'(r_rr_ptr) + i;
      if (w_sum >= N_SRC) begin
        w_sum = w_sum - N_SRC;
      end
      w_idx = SRC_W'(w_sum);
      if (!w_found && src_if.src_req_i[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_rr_next   = (w_winner == SRC_W'(N_SRC - 1)) ? '0 : w_winner + 1'b1;
  assign w_not_full  = (r_used < USED_W'(NUM_SLOTS));
  assign w_fire      = (r_state == S_ARB) && w_found && w_not_full;
  assign w_zero      = w_fire && (w_len_arr[w_winner] == '0);
  assign w_byte      = (r_state == S_STREAM) && src_if.src_valid_i[r_src];
  assign w_last      = w_byte && (r_cnt == r_len - 1'b1);
  assign w_drain_end = (r_drain == DRN_W'(DRAIN_CYCLES - 1));
  assign w_free_ok   = slot_free_i && (r_used != '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ARB: begin
        if (w_fire && !w_zero) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR:  w_next = S_STREAM;
      S_STREAM: begin
        if (w_last) begin
          w_next = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_end) begin
          w_next = S_DONE;
        end
      end
      S_DONE:   w_next = S_ARB;
      default:  w_next = S_ARB;
    endcase
  end

  always_comb begin
    w_grant         = '0;
    w_ready         = '0;
    deser_rst_o     = 1'b0;
    deser_valid_o   = 1'b0;
    deser_data_o    = '0;
    msg_done_o      = 1'b0;
    msg_done_src_o  = '0;
    msg_done_slot_o = '0;
    err_zero_len_o  = 1'b0;
    case (r_state)
      S_ARB: begin
        deser_rst_o = 1'b1;
        if (w_fire) begin
          w_grant[w_winner] = 1'b1;
        end
        err_zero_len_o = w_zero;
      end
      S_CLEAR: begin
        deser_rst_o = 1'b1;
      end
      S_STREAM: begin
        w_ready[r_src] = 1'b1;
        deser_valid_o  = src_if.src_valid_i[r_src];
        deser_data_o   = w_data_arr[r_src];
      end
      S_DONE: begin
        msg_done_o      = 1'b1;
        msg_done_src_o  = r_src;
        msg_done_slot_o = r_wr_slot;
      end
      default: ;
    endcase
  end

  assign src_if.src_grant_o = w_grant;
  assign src_if.src_ready_o = w_ready;
  assign deser_base_addr_o  = r_base;
  assign slots_used_o       = r_used;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= S_ARB;
      r_rr_ptr <= '0;
      r_src    <= '0;
      r_len    <= '0;
    end else begin
      r_state <= w_next;
      if (w_fire) begin
        r_src    <= w_winner;
        r_len    <= w_len_arr[w_winner];
        r_rr_ptr <= w_rr_next;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt   <= '0;
      r_base  <= '0;
      r_drain <= '0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_cnt  <= '0;
        r_base <= cfg_region_base_i + (32'(r_wr_slot) * 32'(SLOT_BYTES));
      end else if (w_byte) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_drain <= (r_state == S_DRAIN) ? r_drain + 1'b1 : '0;
    end
  end

  // A release in the DONE cycle cancels the increment, leaving the count unchanged.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_slot <= '0;
      r_used    <= '0;
    end else begin
      if (r_state == S_DONE) begin
        r_wr_slot <= r_wr_slot + 1'b1;
      end
      if ((r_state == S_DONE) && !w_free_ok) begin
        r_used <= r_used + 1'b1;
      end else if ((r_state != S_DONE) && w_free_ok) begin
        r_used <= r_used - 1'b1;
      end
    end
  end

  a_grant_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(w_grant));
  a_used_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    r_used <= USED_W'(NUM_SLOTS));
  a_valid_in_stream: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    deser_valid_o |-> (r_state == S_STREAM));

endmodule

// File: tb/tb_proto_stream_scheduler.sv
// Directed bench for proto_stream_scheduler: cycle table for a single message plus
// hand-written sequences for round-robin, ring full/wrap, zero length, valid gaps and reset.
module tb_proto_stream_scheduler;
  localparam int unsigned N_SRC        = 4;
  localparam int unsigned NUM_SLOTS    = 8;
  localparam int unsigned SLOT_BYTES   = 4096;
  localparam int unsigned LEN_W        = 16;
  localparam int unsigned DRAIN_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cfg_base;
  logic        slot_free;
  logic [7:0]  deser_data;
  logic        deser_valid;
  logic        deser_rst;
  logic [31:0] deser_base;
  logic        msg_done;
  logic [1:0]  done_src;
  logic [2:0]  done_slot;
  logic [3:0]  slots_used;
  logic        err_zero;

  proto_stream_scheduler_if #(.N_SRC(N_SRC), .LEN_W(LEN_W)) sif ();

  proto_stream_scheduler #(
    .N_SRC(N_SRC), .NUM_SLOTS(NUM_SLOTS), .SLOT_BYTES(SLOT_BYTES),
    .LEN_W(LEN_W), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .src_if(sif),
    .cfg_region_base_i(cfg_base), .slot_free_i(slot_free),
    .deser_data_o(deser_data), .deser_valid_o(deser_valid), .deser_rst_o(deser_rst),
    .deser_base_addr_o(deser_base), .msg_done_o(msg_done), .msg_done_src_o(done_src),
    .msg_done_slot_o(done_slot), .slots_used_o(slots_used), .err_zero_len_o(err_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [7:0] din;
    logic [3:0] gnt;
    logic [3:0] rdy;
    logic       rst;
    logic       dv;
    logic [7:0] dd;
    logic       done;
    logic [3:0] used;
    logic       bset;
  } vec_t;

  typedef struct {
    int          src;
    int          slot;
    logic [31:0] base;
  } done_t;

  int          total = 0;
  int          bad = 0;
  int          g_q[$];
  logic [7:0]  b_q[$];
  done_t       d_q[$];
  int          err_n;
  logic [3:0]  rdy_or;
  int          pend[4];
  int          acc[4];
  vec_t        tv[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < 4; i++) begin
      sif.src_data_i[i*8 +: 8] = 8'(i*16 + acc[i]);
    end
  endtask

  task automatic clear_logs();
    g_q.delete();
    b_q.delete();
    d_q.delete();
    err_n  = 0;
    rdy_or = '0;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 0;
      acc[i]  = 0;
    end
    set_data();
  endtask

  task automatic do_reset();
    sif.src_req_i   = '0;
    sif.src_valid_i = '0;
    slot_free       = 1'b0;
    rst_n           = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
  endtask

  // One cycle per iteration: log outputs at the falling edge, then update sources.
  task automatic run(input int n);
    logic [3:0] g;
    done_t      d;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      g = sif.src_grant_o;
      for (int i = 0; i < 4; i++) begin
        if (g[i]) g_q.push_back(i);
        if (sif.src_ready_o[i] && sif.src_valid_i[i]) acc[i]++;
      end
      rdy_or = rdy_or | sif.src_ready_o;
      if (deser_valid) b_q.push_back(deser_data);
      if (msg_done) begin
        d.src  = int'(done_src);
        d.slot = int'(done_slot);
        d.base = deser_base;
        d_q.push_back(d);
      end
      if (err_zero) err_n++;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (g[i]) begin
          pend[i]--;
          if (pend[i] <= 0) sif.src_req_i[i] = 1'b0;
        end
      end
      set_data();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b;
    int          k2;
    logic        pv[9];

    tv[0]  = '{1'b1, 8'hA0, 4'h1, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0};
    tv[1]  = '{1'b0, 8'hA1, 4'h0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0};
    tv[2]  = '{1'b0, 8'hA2, 4'h0, 4'h1, 1'b0, 1'b1, 8'hA2, 1'b0, 4'd0, 1'b1};
    tv[3]  = '{1'b0, 8'hA3, 4'h0, 4'h1, 1'b0, 1'b1, 8'hA3, 1'b0, 4'd0, 1'b1};
    tv[4]  = '{1'b0, 8'hA4, 4'h0, 4'h1, 1'b0, 1'b1, 8'hA4, 1'b0, 4'd0, 1'b1};
    tv[5]  = '{1'b0, 8'hA5, 4'h0, 4'h1, 1'b0, 1'b1, 8'hA5, 1'b0, 4'd0, 1'b1};
    tv[6]  = '{1'b0, 8'hA6, 4'h0, 4'h1, 1'b0, 1'b1, 8'hA6, 1'b0, 4'd0, 1'b1};
    tv[7]  = '{1'b0, 8'hA7, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1};
    tv[8]  = '{1'b0, 8'hA8, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1};
    tv[9]  = '{1'b0, 8'hA9, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1};
    tv[10] = '{1'b0, 8'hAA, 4'h0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 4'd1, 1'b1};

    sif.src_req_i   = '0;
    sif.src_len_i   = '0;
    sif.src_data_i  = '0;
    sif.src_valid_i = '0;
    slot_free       = 1'b0;
    cfg_base        = 32'h4000_0100;

    // reset state
    #12;
    chk("rst.deser_rst", 32'(deser_rst), 32'd1);
    chk("rst.deser_valid", 32'(deser_valid), 32'd0);
    chk("rst.base", deser_base, 32'd0);
    chk("rst.used", 32'(slots_used), 32'd0);
    chk("rst.done", 32'(msg_done), 32'd0);
    chk("rst.ready", 32'(sif.src_ready_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single message, source 0, len 5, cycle by cycle
    sif.src_len_i[15:0]  = 16'd5;
    sif.src_valid_i[0]   = 1'b1;
    for (int k = 0; k < 11; k++) begin
      sif.src_req_i[0]    = tv[k].req;
      sif.src_data_i[7:0] = tv[k].din;
      @(negedge clk);
      chk($sformatf("t1.grant[%0d]", k), 32'(sif.src_grant_o), 32'(tv[k].gnt));
      chk($sformatf("t1.ready[%0d]", k), 32'(sif.src_ready_o), 32'(tv[k].rdy));
      chk($sformatf("t1.drst[%0d]", k), 32'(deser_rst), 32'(tv[k].rst));
      chk($sformatf("t1.dvalid[%0d]", k), 32'(deser_valid), 32'(tv[k].dv));
      chk($sformatf("t1.ddata[%0d]", k), 32'(deser_data), 32'(tv[k].dd));
      chk($sformatf("t1.done[%0d]", k), 32'(msg_done), 32'(tv[k].done));
      chk($sformatf("t1.slot[%0d]", k), 32'(done_slot), 32'd0);
      chk($sformatf("t1.used[%0d]", k), 32'(slots_used), 32'(tv[k].used));
      chk($sformatf("t1.base[%0d]", k), deser_base, tv[k].bset ? 32'h4000_0100 : 32'd0);
      @(posedge clk);
      #1;
    end

    // 2: all four request, len 3 each
    do_reset();
    cfg_base = 32'h0001_0000;
    for (int i = 0; i < 4; i++) begin
      sif.src_len_i[i*16 +: 16] = 16'd3;
      pend[i] = 1;
    end
    sif.src_valid_i = 4'hF;
    sif.src_req_i   = 4'hF;
    run(40);
    chk("t2.ngrants", 32'(g_q.size()), 32'd4);
    for (int k = 0; k < g_q.size(); k++) chk($sformatf("t2.grant%0d", k), 32'(g_q[k]), 32'(k));
    chk("t2.ndone", 32'(d_q.size()), 32'd4);
    for (int k = 0; k < d_q.size(); k++) begin
      chk($sformatf("t2.dsrc%0d", k), 32'(d_q[k].src), 32'(k));
      chk($sformatf("t2.dslot%0d", k), 32'(d_q[k].slot), 32'(k));
      chk($sformatf("t2.dbase%0d", k), d_q[k].base, 32'h0001_0000 + 32'(k) * 32'd4096);
    end
    chk("t2.nbytes", 32'(b_q.size()), 32'd12);
    for (int j = 0; j < b_q.size(); j++) begin
      k2 = (j / 3) * 16 + (j % 3);
      chk($sformatf("t2.byte%0d", j), 32'(b_q[j]), 32'(k2));
    end
    chk("t2.used", 32'(slots_used), 32'd4);

    // 3: ring fills, ninth request waits, one release lets it through into slot 0
    do_reset();
    cfg_base = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      sif.src_len_i[i*16 +: 16] = 16'd3;
      pend[i] = (i == 0) ? 3 : 2;
    end
    sif.src_valid_i = 4'hF;
    sif.src_req_i   = 4'hF;
    run(70);
    chk("t3.used_full", 32'(slots_used), 32'd8);
    chk("t3.ngrants", 32'(g_q.size()), 32'd8);
    for (int k = 0; k < g_q.size(); k++) chk($sformatf("t3.grant%0d", k), 32'(g_q[k]), 32'(k % 4));
    chk("t3.ndone", 32'(d_q.size()), 32'd8);
    for (int k = 0; k < d_q.size(); k++) chk($sformatf("t3.dslot%0d", k), 32'(d_q[k].slot), 32'(k));
    run(20);
    chk("t3.no_grant_full", 32'(g_q.size()), 32'd8);
    chk("t3.drst_full", 32'(deser_rst), 32'd1);
    slot_free = 1'b1;
    run(1);
    slot_free = 1'b0;
    chk("t3.no_grant_same", 32'(g_q.size()), 32'd8);
    run(1);
    chk("t3.grant_after_free", 32'(g_q.size()), 32'd9);
    run(12);
    chk("t3.ndone2", 32'(d_q.size()), 32'd9);
    if (d_q.size() == 9) begin
      chk("t3.wrap_slot", 32'(d_q[8].slot), 32'd0);
      chk("t3.wrap_src", 32'(d_q[8].src), 32'd0);
      chk("t3.wrap_base", d_q[8].base, 32'h8000_0000);
    end
    chk("t3.used_end", 32'(slots_used), 32'd8);

    // 4: zero-length message on source 2 is dropped, source 3 follows
    do_reset();
    cfg_base = 32'h0000_1000;
    sif.src_len_i[2*16 +: 16] = 16'd0;
    sif.src_len_i[3*16 +: 16] = 16'd2;
    pend[2] = 1;
    pend[3] = 1;
    sif.src_valid_i = 4'hF;
    sif.src_req_i   = 4'b1100;
    run(1);
    chk("t4.err", 32'(err_n), 32'd1);
    chk("t4.first_grant", (g_q.size() > 0) ? 32'(g_q[0]) : 32'hFFFF_FFFF, 32'd2);
    chk("t4.used_unch", 32'(slots_used), 32'd0);
    run(1);
    chk("t4.next_grant", (g_q.size() > 1) ? 32'(g_q[1]) : 32'hFFFF_FFFF, 32'd3);
    run(13);
    chk("t4.err_total", 32'(err_n), 32'd1);
    chk("t4.nbytes", 32'(b_q.size()), 32'd2);
    for (int j = 0; j < b_q.size(); j++) chk($sformatf("t4.byte%0d", j), 32'(b_q[j]), 32'h30 + 32'(j));
    chk("t4.ndone", 32'(d_q.size()), 32'd1);
    if (d_q.size() == 1) begin
      chk("t4.dsrc", 32'(d_q[0].src), 32'd3);
      chk("t4.dslot", 32'(d_q[0].slot), 32'd0);
    end
    chk("t4.used", 32'(slots_used), 32'd1);

    // 5: valid gaps 1,0,0,1,1 on source 1 with len 3
    do_reset();
    sif.src_len_i[1*16 +: 16] = 16'd3;
    pend[1] = 1;
    sif.src_valid_i = 4'b1101;
    sif.src_req_i   = 4'b0010;
    run(1);
    pv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 9; c++) begin
      sif.src_valid_i[1] = pv[c];
      run(1);
    end
    run(2);
    chk("t5.nbytes", 32'(b_q.size()), 32'd3);
    for (int j = 0; j < b_q.size(); j++) chk($sformatf("t5.byte%0d", j), 32'(b_q[j]), 32'h10 + 32'(j));
    chk("t5.accepted", 32'(acc[1]), 32'd3);
    chk("t5.ready_mask", 32'(rdy_or), 32'h2);
    chk("t5.ndone", 32'(d_q.size()), 32'd1);
    if (d_q.size() == 1) chk("t5.dsrc", 32'(d_q[0].src), 32'd1);

    // 6: reset in the middle of a 10-byte message, then a fresh message
    do_reset();
    cfg_base = 32'h0000_2000;
    sif.src_len_i[15:0] = 16'd10;
    pend[0] = 1;
    sif.src_valid_i = 4'hF;
    sif.src_req_i   = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      if (b_q.size() >= 2) break;
      run(1);
    end
    chk("t6.reached_byte2", 32'(b_q.size()), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.drst", 32'(deser_rst), 32'd1);
    chk("t6.dvalid", 32'(deser_valid), 32'd0);
    chk("t6.ready", 32'(sif.src_ready_o), 32'd0);
    chk("t6.base", deser_base, 32'd0);
    chk("t6.used", 32'(slots_used), 32'd0);
    sif.src_req_i   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    sif.src_len_i[1*16 +: 16] = 16'd2;
    pend[1] = 1;
    sif.src_req_i = 4'b0010;
    run(12);
    chk("t6.ndone", 32'(d_q.size()), 32'd1);
    if (d_q.size() == 1) begin
      chk("t6.dslot", 32'(d_q[0].slot), 32'd0);
      chk("t6.dsrc", 32'(d_q[0].src), 32'd1);
      b = d_q[0].base;
      chk("t6.dbase", b, 32'h0000_2000);
    end
    chk("t6.nbytes", 32'(b_q.size()), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
